// File: rtl/mult_seq5.sv
// Sequential 5x5 unsigned shift-and-add multiplier over one somador5Bits ripple adder.
// Optional build macro: MULT_ZERO_SKIP_EN (zero operand short-circuits straight to completion).

// 5-bit ripple-carry adder, explicit full-adder chain.
// Latency: combinational.
// Backpressure: none.
module somador5Bits (
  input  logic [4:0] num1,
  input  logic [4:0] num2,
  output logic [4:0] s,
  output logic       cout
);

  logic [5:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 5; i++) begin : g_fa
    assign s[i]   = num1[i] ^ num2[i] ^ c[i];
    assign c[i+1] = (num1[i] & num2[i]) | (c[i] & (num1[i] ^ num2[i]));
  end

  assign cout = c[5];

endmodule

// Shift-and-add multiplier controller with start/busy/done handshake.
// Latency: accept at E0, done/produto valid E5..E6, idle again at E6.
// Backpressure: start is sampled only while idle; requests during busy/done are dropped.
module mult_seq5 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] num1,
  input  logic [4:0] num2,
  output logic [9:0] produto,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] OCIOSO = 2'd0;
  localparam logic [1:0] SOMA   = 2'd1;
  localparam logic [1:0] FIM    = 2'd2;
`ifdef MULT_ZERO_SKIP_EN
  // One idle-looking cycle so the skip completion lands on the same edge grid as a real accept.
  localparam logic [1:0] ZERO   = 2'd3;
`endif

  logic [1:0] estado;
  logic [1:0] estado_nxt;
  logic [4:0] a;
  logic [4:0] p;
  logic [4:0] q;
  logic [2:0] cnt;
  logic       busy_nxt;
  logic       done_nxt;

  logic [4:0] sum_s;
  logic       sum_c;
  logic [4:0] sh_s;
  logic       sh_c;
  logic [9:0] pq_nxt;

  somador5Bits u_add (
    .num1 (p),
    .num2 (a),
    .s    (sum_s),
    .cout (sum_c)
  );

  // Multiplier LSB selects between P+A and P; the carry is shifted into the top.
  always_comb begin
    sh_s   = q[0] ? sum_s : p;
    sh_c   = q[0] ? sum_c : 1'b0;
    pq_nxt = {sh_c, sh_s, q[4:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_nxt;
    end
  end

  always_comb begin
    estado_nxt = estado;
    case (estado)
      OCIOSO: begin
        if (start) begin
`ifdef MULT_ZERO_SKIP_EN
          if (num1 == 5'd0 || num2 == 5'd0) estado_nxt = ZERO;
          else
`endif
          estado_nxt = SOMA;
        end
      end
      SOMA: begin
        if (cnt == 3'd4) estado_nxt = FIM;
      end
      FIM: begin
        estado_nxt = OCIOSO;
      end
      default: begin
`ifdef MULT_ZERO_SKIP_EN
        estado_nxt = FIM;
`else
        estado_nxt = OCIOSO;
`endif
      end
    endcase
  end

  always_comb begin
    busy_nxt = (estado_nxt == SOMA);
    done_nxt = (estado_nxt == FIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= 5'd0;
      p       <= 5'd0;
      q       <= 5'd0;
      cnt     <= 3'd0;
      produto <= 10'd0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (start) begin
            a   <= num1;
            q   <= num2;
            p   <= 5'd0;
            cnt <= 3'd0;
          end
        end
        SOMA: begin
          {p, q} <= pq_nxt;
          cnt    <= cnt + 3'd1;
          // The last iteration's shift result is the product, captured on FIM entry.
          if (cnt == 3'd4) produto <= pq_nxt;
        end
`ifdef MULT_ZERO_SKIP_EN
        ZERO: begin
          produto <= 10'd0;
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq5.sv
// Scoreboard bench for mult_seq5: directed cases, reset abort and an exhaustive operand sweep.
module tb_mult_seq5;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] num1;
  logic [4:0] num2;
  logic [9:0] produto;
  logic       busy;
  logic       done;

  typedef struct {
    int prod;
    int acc;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec;
  int   n_err;
  int   cyc;
  int   last_prod;

  mult_seq5 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .num1    (num1),
    .num2    (num2),
    .produto (produto),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit skip_zero(input int x, input int y);
`ifdef MULT_ZERO_SKIP_EN
    return (x == 0 || y == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Edges from accept to done; the accept-to-accept period adds the FIM and idle edges.
  function automatic int lat_of(input int x, input int y);
    return skip_zero(x, y) ? 1 : 5;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("done_busy_excl", busy, 0);
      if (sb_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("produto", produto, e.prod);
        chk("latency", cyc - e.acc, e.lat);
        last_prod = e.prod;
      end
    end
  end

  // Drives one request; with hold=1 start stays high across the whole busy/done window.
  task automatic issue(input int x, input int y, input bit hold);
    exp_t e;
    @(negedge clk);
    num1  = 5'(x);
    num2  = 5'(y);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("produto_kept_on_start", produto, last_prod);
    e.prod = x * y;
    e.acc  = cyc;
    e.lat  = lat_of(x, y);
    sb_q.push_back(e);
    num1 = 5'($urandom_range(31));
    num2 = 5'($urandom_range(31));
    if (!hold) start = 1'b0;
    repeat (e.lat + 1) @(posedge clk);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    start = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    cyc       = 0;
    last_prod = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    num1      = 5'd0;
    num2      = 5'd0;
    #1;
    chk("rst_produto", produto, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 13x11 with explicit busy window and output hold afterwards.
    @(negedge clk);
    num1  = 5'd13;
    num2  = 5'd11;
    start = 1'b1;
    @(posedge clk);
    #1;
    sb_q.push_back('{143, cyc, 5});
    start = 1'b0;
    num1  = 5'd2;
    num2  = 5'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_window", busy, 1);
      chk("done_early", done, 0);
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    repeat (10) @(negedge clk);
    chk("produto_hold", produto, 143);
    chk("done_cleared", done, 0);

    issue(31, 31, 1'b0);
    drain();
    issue(1, 16, 1'b0);
    drain();

    // Back-to-back with start held; operands are scrambled right after each accept.
    issue(5, 6, 1'b1);
    issue(7, 3, 1'b1);
    start = 1'b0;
    drain();

    // Zero operand: full path by default, immediate completion with the skip macro.
    @(negedge clk);
    num1  = 5'd0;
    num2  = 5'd17;
    start = 1'b1;
    @(posedge clk);
    #1;
    sb_q.push_back('{0, cyc, lat_of(0, 17)});
    start = 1'b0;
    @(negedge clk);
    chk("zero_busy", busy, skip_zero(0, 17) ? 0 : 1);
    drain();
    repeat (2) @(negedge clk);

    // Reset in the middle of 9x9: outputs clear at once and no done follows.
    issue(3, 5, 1'b0);
    drain();
    repeat (2) @(negedge clk);
    num1  = 5'd9;
    num2  = 5'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    last_prod = 0;
    #1;
    chk("abort_produto", produto, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done_produto", produto, 0);
    issue(9, 9, 1'b0);
    drain();

    // Exhaustive sweep, start held high the whole time.
    for (int x = 0; x < 32; x++) begin
      for (int y = 0; y < 32; y++) begin
        issue(x, y, 1'b1);
      end
    end
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
